// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ requesters.
// Multi-byte packets hold a lock on the transmitter until their last byte.
// A stalled lock is dropped after LOCK_TIMEOUT idle cycles.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for tx_busy=0 and an eligible requester
// LAUNCH | req_ready/tx_latch pulse for the accepted byte
// SETTLE | one-cycle guard while the transmitter registers the frame
// DRAIN  | waiting for tx_busy to fall
module uart_tx_arbiter #(
   parameter int NREQ         = 4,
   parameter int IDW          = 2,
   parameter int LOCK_TIMEOUT = 2780,
   parameter int TW           = 12
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_last,
   output logic [NREQ-1:0]   req_ready,
   output logic [7:0]        tx_data,
   output logic              tx_latch,
   input  logic              tx_busy,
   output logic [IDW-1:0]    grant,
   output logic              locked,
   output logic              active
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      SETTLE = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW-1:0] grant_q, grant_d;
   logic           locked_q, locked_d;
   logic [7:0]     tx_data_q, tx_data_d;
   logic [TW-1:0]  tout_q, tout_d;

   logic           win_found;
   logic [IDW-1:0] win_idx;
   logic [IDW-1:0] cand;
   logic           grant_vld;

   // Index of the next requester in modulo-NREQ order.
   function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
      return (v == IDW'(NREQ - 1)) ? '0 : v + 1'b1;
   endfunction

   assign grant_vld = req_valid[grant_q];

   // Winner selection: the locked owner only, else first valid from ptr onward.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = ptr_q;
      if (locked_q) begin
         win_found = grant_vld;
         win_idx   = grant_q;
      end else begin
         for (int k = 0; k < NREQ; k++) begin
            if (!win_found && req_valid[cand]) begin
               win_found = 1'b1;
               win_idx   = cand;
            end
            cand = wrap_inc(cand);
         end
      end
   end

   // Next-state logic, accept bookkeeping and lock timeout.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      locked_d  = locked_q;
      tx_data_d = tx_data_q;
      tout_d    = tout_q;

      // Any sign of life from the owner restarts the stall timer.
      if (grant_vld) begin
         tout_d = '0;
      end

      unique case (state_q)
         IDLE: begin
            if (!tx_busy && win_found) begin
               tx_data_d = req_data[{win_idx, 3'b000} +: 8];
               grant_d   = win_idx;
               locked_d  = ~req_last[win_idx];
               tout_d    = '0;
               if (req_last[win_idx]) begin
                  ptr_d = wrap_inc(win_idx);
               end
               state_d = LAUNCH;
            end else if (locked_q && !grant_vld) begin
               // An accept in the expiry cycle takes the branch above, so
               // a returning owner always keeps its lock.
               if (tout_q >= TW'(LOCK_TIMEOUT - 1)) begin
                  locked_d = 1'b0;
                  ptr_d    = wrap_inc(grant_q);
                  tout_d   = '0;
               end else if (tout_q != '1) begin
                  tout_d = tout_q + 1'b1;
               end
            end
         end
         LAUNCH: begin
            state_d = SETTLE;
         end
         SETTLE: begin
            state_d = DRAIN;
         end
         DRAIN: begin
            // A refused byte (tx_busy never rose) is dropped, not retried.
            if (!tx_busy) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         grant_q   <= '0;
         locked_q  <= 1'b0;
         tx_data_q <= 8'h00;
         tout_q    <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         locked_q  <= locked_d;
         tx_data_q <= tx_data_d;
         tout_q    <= tout_d;
      end
   end

   // Strobes decode straight from the state so reset clears them at once.
   always_comb begin
      tx_latch  = (state_q == LAUNCH);
      req_ready = tx_latch ? (NREQ'(1) << grant_q) : '0;
   end

   assign tx_data = tx_data_q;
   assign grant   = grant_q;
   assign locked  = locked_q;
   assign active  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table vectors, hand sequences for lock,
// timeout, reset and refusal, and randomized packets against a queue model.
module tb_uart_tx_arbiter;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              nrst = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [8*NREQ-1:0] req_data = '0;
   logic [NREQ-1:0]   req_last = '0;
   logic [NREQ-1:0]   req_ready;
   logic [7:0]        tx_data;
   logic              tx_latch;
   logic              tx_busy = 1'b0;
   logic [IDW-1:0]    grant;
   logic              locked;
   logic              active;

   uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW), .LOCK_TIMEOUT(2780), .TW(12)) dut (
      .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
      .tx_latch(tx_latch), .tx_busy(tx_busy), .grant(grant),
      .locked(locked), .active(active));

   always #5 clk = ~clk;

   // Transmitter stand-in: busy for frame_len cycles after a latch, no reset.
   int frame_len = 8;
   bit refuse = 1'b0;
   int busy_cnt = 0;
   always @(posedge clk) begin
      if (!tx_busy) begin
         if (tx_latch && !refuse) begin
            tx_busy  <= 1'b1;
            busy_cnt <= frame_len - 1;
         end
      end else if (busy_cnt == 0) begin
         tx_busy <= 1'b0;
      end else begin
         busy_cnt <= busy_cnt - 1;
      end
   end

   typedef struct {
      int         g;
      logic [7:0] d;
      logic       l;
   } acc_t;

   typedef struct {
      logic [3:0] valid;
      logic [3:0] last;
      int         exp_g;
      logic       exp_l;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   drv_en = 1'b0;
   bit   rand_frames = 1'b0;
   bit   rand_refuse = 1'b0;
   logic [8:0] rq [NREQ][$];
   logic [8:0] mq [NREQ][$];
   acc_t acc_q[$];
   acc_t exp_q[$];
   logic [7:0] lane_d [NREQ];
   vec_t vt [6];
   int   rr_exp [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive_reqs();
      for (int i = 0; i < NREQ; i++) begin
         if (rq[i].size() > 0) begin
            req_valid[i]        = 1'b1;
            req_data[8*i +: 8]  = rq[i][0][7:0];
            req_last[i]         = rq[i][0][8];
         end else begin
            req_valid[i] = 1'b0;
            req_last[i]  = 1'b0;
         end
      end
   endtask

   // One cycle: sample at the falling edge, log accepts, then update drivers.
   task automatic tick();
      logic [8:0] dummy;
      @(negedge clk);
      cyc++;
      if (tx_latch || req_ready != '0) begin
         chk("ready_onehot", 32'(req_ready), 32'(4'(1) << grant));
         chk("latch_with_ready", 32'(tx_latch), 32'd1);
         chk("no_latch_while_busy", 32'(tx_busy), 32'd0);
         acc_q.push_back('{int'(grant), tx_data, locked});
         if (drv_en) begin
            for (int i = 0; i < NREQ; i++) begin
               if (req_ready[i] && rq[i].size() > 0) dummy = rq[i].pop_front();
            end
         end
      end
      if (drv_en) drive_reqs();
      if (rand_frames) frame_len = $urandom_range(1, 12);
      refuse = rand_refuse ? ($urandom_range(0, 9) == 0) : refuse;
   endtask

   task automatic wait_latch(input int max, input string name);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < max && !ok; n++) begin
         tick();
         if (tx_latch) ok = 1'b1;
      end
      chk({name, "_latch_seen"}, 32'(ok), 32'd1);
   endtask

   task automatic push_byte(input int i, input logic last, input logic [7:0] d);
      rq[i].push_back({last, d});
      mq[i].push_back({last, d});
   endtask

   task automatic do_reset();
      drv_en = 1'b0; rand_frames = 1'b0; rand_refuse = 1'b0;
      refuse = 1'b0; frame_len = 8;
      req_valid = '0; req_last = '0; req_data = '0;
      for (int n = 0; n < 200 && tx_busy; n++) tick();
      nrst = 1'b0;
      repeat (2) tick();
      nrst = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         rq[i].delete();
         mq[i].delete();
      end
      acc_q.delete();
      exp_q.delete();
   endtask

   // Reference: order of accepted bytes from the queued packets, starting
   // from reset (pointer 0, unlocked). Every queued byte stays offered.
   task automatic model_build();
      int ptr; int g; bit lk; int w; int c;
      logic [8:0] b;
      ptr = 0; g = 0; lk = 1'b0;
      exp_q.delete();
      for (int guard = 0; guard < 1000; guard++) begin
         w = -1;
         if (lk) begin
            if (mq[g].size() > 0) w = g;
         end else begin
            for (int k = 0; k < NREQ; k++) begin
               c = (ptr + k) % NREQ;
               if (w < 0 && mq[c].size() > 0) w = c;
            end
         end
         if (w < 0) break;
         b = mq[w].pop_front();
         exp_q.push_back('{w, b[7:0], ~b[8]});
         g  = w;
         lk = ~b[8];
         if (b[8]) ptr = (w + 1) % NREQ;
      end
   endtask

   task automatic run_and_compare(input string name);
      for (int n = 0; n < 20000 && acc_q.size() < exp_q.size(); n++) tick();
      repeat (30) tick();
      chk({name, "_count"}, 32'(acc_q.size()), 32'(exp_q.size()));
      for (int k = 0; k < acc_q.size() && k < exp_q.size(); k++) begin
         chk({name, "_grant"}, 32'(acc_q[k].g), 32'(exp_q[k].g));
         chk({name, "_data"}, 32'(acc_q[k].d), 32'(exp_q[k].d));
         chk({name, "_locked"}, 32'(acc_q[k].l), 32'(exp_q[k].l));
      end
   endtask

   int idle;

   initial begin
      lane_d = '{8'h55, 8'h66, 8'h77, 8'h88};
      vt[0] = '{4'b0001, 4'b1111, 0, 1'b0};
      vt[1] = '{4'b0110, 4'b0000, 1, 1'b1};
      vt[2] = '{4'b1000, 4'b0000, 3, 1'b1};
      vt[3] = '{4'b1111, 4'b1110, 0, 1'b1};
      vt[4] = '{4'b1100, 4'b1111, 2, 1'b0};
      vt[5] = '{4'b1010, 4'b0010, 1, 1'b0};
      rr_exp = '{0, 1, 2, 3, 0};

      // Reset values while nrst is held low.
      @(posedge clk);
      #1;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_latch", 32'(tx_latch), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_active", 32'(active), 32'd0);

      // Table vectors: single accept from reset, one cycle latency.
      for (int v = 0; v < 6; v++) begin
         do_reset();
         req_data  = {lane_d[3], lane_d[2], lane_d[1], lane_d[0]};
         req_valid = vt[v].valid;
         req_last  = vt[v].last;
         tick();
         chk("vec_latch", 32'(tx_latch), 32'd1);
         chk("vec_ready", 32'(req_ready), 32'(4'(1) << vt[v].exp_g));
         chk("vec_grant", 32'(grant), 32'(vt[v].exp_g));
         chk("vec_locked", 32'(locked), 32'(vt[v].exp_l));
         chk("vec_tx_data", 32'(tx_data), 32'(lane_d[vt[v].exp_g]));
         chk("vec_active", 32'(active), 32'd1);
         req_valid = '0;
         for (int n = 0; n < 50 && active; n++) tick();
         chk("vec_back_idle", 32'(active), 32'd0);
      end

      // Round robin among four always-valid single-byte packets.
      do_reset();
      drv_en = 1'b1;
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < NREQ; i++) push_byte(i, 1'b1, 8'(8'hA0 + i));
      model_build();
      run_and_compare("rr");
      for (int k = 0; k < 5; k++)
         if (acc_q.size() > k) chk("rr_order", 32'(acc_q[k].g), 32'(rr_exp[k]));

      // Packet lock: requester 2 keeps the transmitter for 3 bytes.
      do_reset();
      drv_en = 1'b1;
      push_byte(2, 1'b0, 8'h10);
      push_byte(2, 1'b0, 8'h11);
      push_byte(2, 1'b1, 8'h12);
      wait_latch(10, "pk0");
      chk("pk0_grant", 32'(grant), 32'd2);
      chk("pk0_locked", 32'(locked), 32'd1);
      push_byte(0, 1'b1, 8'h01);
      push_byte(1, 1'b1, 8'h02);
      wait_latch(40, "pk1");
      chk("pk1_grant", 32'(grant), 32'd2);
      chk("pk1_data", 32'(tx_data), 32'h11);
      chk("pk1_locked", 32'(locked), 32'd1);
      wait_latch(40, "pk2");
      chk("pk2_grant", 32'(grant), 32'd2);
      chk("pk2_data", 32'(tx_data), 32'h12);
      chk("pk2_locked", 32'(locked), 32'd0);
      wait_latch(40, "pk3");
      chk("pk3_grant", 32'(grant), 32'd0);
      wait_latch(40, "pk4");
      chk("pk4_grant", 32'(grant), 32'd1);

      // Lock timeout: owner goes quiet, pending requester 2 served after expiry.
      do_reset();
      drv_en = 1'b1;
      push_byte(1, 1'b0, 8'h31);
      push_byte(2, 1'b1, 8'h22);
      wait_latch(10, "to0");
      chk("to0_grant", 32'(grant), 32'd1);
      chk("to0_locked", 32'(locked), 32'd1);
      idle = 0;
      for (int n = 0; n < 6000 && locked; n++) begin
         tick();
         if (locked && !active) idle++;
      end
      chk("to_idle_cycles", 32'(idle), 32'd2780);
      chk("to_unlocked", 32'(locked), 32'd0);
      wait_latch(3, "to1");
      chk("to1_grant", 32'(grant), 32'd2);
      chk("to1_data", 32'(tx_data), 32'h22);

      // Owner returns in the expiry cycle: accept wins, lock is kept.
      do_reset();
      drv_en = 1'b1;
      push_byte(1, 1'b0, 8'h31);
      push_byte(2, 1'b1, 8'h22);
      wait_latch(10, "tk0");
      idle = 0;
      for (int n = 0; n < 6000 && locked && idle < 2780; n++) begin
         tick();
         if (locked && !active) idle++;
      end
      chk("tk_idle_cycles", 32'(idle), 32'd2780);
      push_byte(1, 1'b0, 8'h32);
      drive_reqs();
      wait_latch(2, "tk1");
      chk("tk1_grant", 32'(grant), 32'd1);
      chk("tk1_data", 32'(tx_data), 32'h32);
      chk("tk1_locked", 32'(locked), 32'd1);
      push_byte(1, 1'b1, 8'h33);
      wait_latch(40, "tk2");
      chk("tk2_grant", 32'(grant), 32'd1);
      chk("tk2_locked", 32'(locked), 32'd0);
      wait_latch(40, "tk3");
      chk("tk3_grant", 32'(grant), 32'd2);

      // Reset mid-DRAIN: outputs clear at once, no latch until the frame ends.
      do_reset();
      drv_en = 1'b1;
      frame_len = 40;
      push_byte(3, 1'b0, 8'hC1);
      push_byte(3, 1'b1, 8'hC2);
      wait_latch(10, "mr0");
      chk("mr0_grant", 32'(grant), 32'd3);
      repeat (5) tick();
      chk("mr_in_drain", 32'(active), 32'd1);
      #2;
      nrst = 1'b0;
      #1;
      chk("mr_ready", 32'(req_ready), 32'd0);
      chk("mr_latch", 32'(tx_latch), 32'd0);
      chk("mr_grant", 32'(grant), 32'd0);
      chk("mr_locked", 32'(locked), 32'd0);
      chk("mr_tx_data", 32'(tx_data), 32'd0);
      chk("mr_active", 32'(active), 32'd0);
      repeat (10) tick();
      nrst = 1'b1;
      for (int n = 0; n < 100 && tx_busy; n++) begin
         tick();
         if (tx_busy) chk("mr_no_latch_busy", 32'(tx_latch), 32'd0);
      end
      wait_latch(10, "mr1");
      chk("mr1_grant", 32'(grant), 32'd3);
      chk("mr1_data", 32'(tx_data), 32'hC2);
      chk("mr1_locked", 32'(locked), 32'd0);

      // Transmitter refuses: back to IDLE 3 cycles after LAUNCH, no retry.
      do_reset();
      drv_en = 1'b1;
      refuse = 1'b1;
      push_byte(0, 1'b1, 8'hD0);
      push_byte(1, 1'b1, 8'hD1);
      wait_latch(10, "rf0");
      chk("rf0_grant", 32'(grant), 32'd0);
      tick(); chk("rf_settle_active", 32'(active), 32'd1);
      tick(); chk("rf_drain_active", 32'(active), 32'd1);
      tick(); chk("rf_idle", 32'(active), 32'd0);
      tick();
      chk("rf1_latch", 32'(tx_latch), 32'd1);
      chk("rf1_grant", 32'(grant), 32'd1);
      chk("rf1_data", 32'(tx_data), 32'hD1);

      // Randomized packets, frame lengths and occasional refusals.
      for (int it = 0; it < 4; it++) begin
         do_reset();
         for (int i = 0; i < NREQ; i++) begin
            int npk;
            npk = $urandom_range(0, 3);
            for (int p = 0; p < npk; p++) begin
               int len;
               len = $urandom_range(1, 3);
               for (int j = 0; j < len; j++) push_byte(i, (j == len - 1), 8'($urandom));
            end
         end
         drv_en = 1'b1;
         rand_frames = 1'b1;
         rand_refuse = 1'b1;
         model_build();
         run_and_compare("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
